// File: rtl/shiftreg_3bit.sv
// Serial-in/parallel-out shift register: one bit captured per rising edge,
// newest bit in q[0], oldest in q[WIDTH-1], synchronous active-low reset.
module shiftreg_3bit #(
    parameter int              WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // A single-stage register has no older bits to carry, so it needs its
    // own form to avoid an empty part-select.
    generate
        if (WIDTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!reset) begin
                    q <= RESET_VALUE;
                end else begin
                    q <= d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!reset) begin
                    q <= RESET_VALUE;
                end else begin
                    q <= {q[WIDTH-2:0], d};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_shiftreg_3bit.sv
// Self-checking bench for shiftreg_3bit: directed scenarios plus randomized
// traffic checked against a bit-history model of the register.
module tb_shiftreg_3bit;

    localparam int W = 3;

    logic         clk;
    logic         reset;
    logic         d;
    logic [W-1:0] q;

    int checks;
    int errors;

    // Bits accepted since the last reset, oldest first.
    bit hist[$];

    shiftreg_3bit #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected register contents: bit k is the value captured k+1 edges ago,
    // or zero when fewer than k+1 bits have arrived since reset.
    function automatic logic [W-1:0] model_q();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++) begin
            if (hist.size() > k) r[k] = hist[hist.size() - 1 - k];
        end
        return r;
    endfunction

    // Drives inputs away from the edge, lets one rising edge pass, then
    // updates the model so q can be sampled 1 time unit after the edge.
    task automatic drive(input logic r, input logic dv);
        @(negedge clk);
        reset = r;
        d     = dv;
        @(posedge clk);
        #1;
        if (!r) begin
            hist.delete();
        end else begin
            hist.push_back(dv);
            if (hist.size() > W) void'(hist.pop_front());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        d     = 1'b1;
        @(posedge clk);
        #1;
        hist.delete();
        checks++;
        if (q !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_first_edge: got %b expected %b", q, 3'b000);
        end
        drive(1'b0, 1'b0);
        checks++;
        if (q !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_second_edge: got %b expected %b", q, 3'b000);
        end
    endtask

    task automatic test_walking_one();
        logic       din [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] exp [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
        drive(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, din[i]);
            checks++;
            if (q !== exp[i]) begin
                errors++;
                $display("[TB] FAIL walking_one[%0d]: got %b expected %b", i, q, exp[i]);
            end
        end
    endtask

    task automatic test_pattern();
        logic       din [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp [5] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b110};
        drive(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, din[i]);
            checks++;
            if (q !== exp[i]) begin
                errors++;
                $display("[TB] FAIL pattern_10110[%0d]: got %b expected %b", i, q, exp[i]);
            end
        end
    endtask

    task automatic test_steady_ones();
        logic [2:0] exp [4] = '{3'b001, 3'b011, 3'b111, 3'b111};
        drive(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1);
            checks++;
            if (q !== exp[i]) begin
                errors++;
                $display("[TB] FAIL steady_ones[%0d]: got %b expected %b", i, q, exp[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        checks++;
        if (q !== 3'b111) begin
            errors++;
            $display("[TB] FAIL midstream_fill: got %b expected %b", q, 3'b111);
        end
        drive(1'b0, 1'b1);
        checks++;
        if (q !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midstream_clear: got %b expected %b", q, 3'b000);
        end
        drive(1'b1, 1'b1);
        checks++;
        if (q !== 3'b001) begin
            errors++;
            $display("[TB] FAIL midstream_resume: got %b expected %b", q, 3'b001);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            checks++;
            if (q !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_priority[%0d]: got %b expected %b", i, q, 3'b000);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) != 0), 1'($urandom));
            exp = model_q();
            checks++;
            if (q !== exp) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %b expected %b", i, q, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        d      = 1'b0;
        test_reset();
        test_walking_one();
        test_pattern();
        test_steady_ones();
        test_midstream_reset();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
